// File: rtl/controle_servo_pwm.sv
// -----------------------------------------------------------------------------
// controle_servo_pwm
//
// Servo PWM generator placed right after the up/down position counter of the
// sweep datapath. Turns an N-bit position into a fixed-period pulse whose
// width grows linearly with position:
//   largura = LARG_MIN + posicao_atual * PASSO  (saturated to PERIODO-1)
// The position is sampled only at period boundaries, so a pulse is never
// glitched by a position change in mid-period. A one-cycle end-of-period
// strobe (fim_periodo) can drive the counter's count-enable, which advances
// the sweep exactly once per servo period.
//
// Ports
//   clock          in   system clock, all state on the rising edge
//   zera_as_n      in   asynchronous active-low reset
//   liga           in   enable, sampled on every rising edge
//   posicao        in   [N-1:0] position from the up/down counter
//   pwm            out  servo drive pulse
//   fim_periodo    out  high during the last cycle of each active period
//   ativo          out  high while the state machine is in ATIVO
//   posicao_atual  out  [N-1:0] position currently being driven (latched)
// -----------------------------------------------------------------------------
module controle_servo_pwm #(
  parameter int PERIODO  = 1_000_000,
  parameter int LARG_MIN = 50_000,
  parameter int PASSO    = 7_143,
  parameter int N        = 3,
  parameter int W        = 20
) (
  input  logic         clock,
  input  logic         zera_as_n,
  input  logic         liga,
  input  logic [N-1:0] posicao,
  output logic         pwm,
  output logic         fim_periodo,
  output logic         ativo,
  output logic [N-1:0] posicao_atual
);

  // Reject parameter sets where the widest pulse would not fit in the
  // period, or where the period counter cannot hold PERIODO-1.
  if (LARG_MIN + ((2 ** N) - 1) * PASSO >= PERIODO) begin : g_largura_invalida
    $fatal(1, "controle_servo_pwm: LARG_MIN + (2^N-1)*PASSO must be < PERIODO");
  end
  if ((2 ** W) <= PERIODO) begin : g_largura_w_invalida
    $fatal(1, "controle_servo_pwm: 2^W must be > PERIODO");
  end

  localparam logic [W-1:0] L_ULTIMO   = W'(PERIODO - 1);
  localparam logic [W-1:0] L_LARG_MIN = W'(LARG_MIN);
  localparam logic [W-1:0] L_PASSO    = W'(PASSO);

  typedef enum logic {
    PARADO = 1'b0,
    ATIVO  = 1'b1
  } estado_t;

  estado_t        r_estado;
  estado_t        w_estado_prox;
  logic [W-1:0]   r_contador;
  logic [N-1:0]   r_posicao_atual;

  logic           w_ativo;
  logic           w_fim;
  logic [W-1:0]   w_largura_bruta;
  logic [W-1:0]   w_largura;

  // ---------------------------------------------------------------------------
  // Pulse width from the latched position. Only registered state feeds this,
  // so the outputs have no combinational path from any input.
  // ---------------------------------------------------------------------------
  assign w_largura_bruta = L_LARG_MIN + (W'(r_posicao_atual) * L_PASSO);
  assign w_largura       = (w_largura_bruta > L_ULTIMO) ? L_ULTIMO : w_largura_bruta;

  assign w_ativo = (r_estado == ATIVO);
  assign w_fim   = w_ativo && (r_contador == L_ULTIMO);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      r_estado <= PARADO;
    end else begin
      r_estado <= w_estado_prox;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Stopping is only honoured at the wrap, so the current
  // period always runs to completion.
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first guarantees every path drives
  // w_estado_prox, which keeps this block from inferring a latch.
  always_comb begin
    w_estado_prox = r_estado;
    case (r_estado)
      PARADO: if (liga)          w_estado_prox = ATIVO;
      ATIVO:  if (w_fim && !liga) w_estado_prox = PARADO;
      default:                   w_estado_prox = PARADO;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Period counter and position latch. The position is captured on the start
  // edge and on every wrap edge, i.e. the value present just before the edge.
  // With fim_periodo looped back to the counter's count-enable, this sees the
  // pre-increment position, giving a one-period lag behind the counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      r_contador      <= '0;
      r_posicao_atual <= '0;
    end else begin
      case (r_estado)
        PARADO: begin
          r_contador <= '0;
          if (liga) begin
            r_posicao_atual <= posicao;
          end
        end
        ATIVO: begin
          if (w_fim) begin
            r_contador      <= '0;
            r_posicao_atual <= posicao;
          end else begin
            r_contador <= r_contador + W'(1);
          end
        end
        default: begin
          r_contador <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: pure decode of registered state.
  // ---------------------------------------------------------------------------
  assign pwm           = w_ativo && (r_contador < w_largura);
  assign fim_periodo   = w_fim;
  assign ativo         = w_ativo;
  assign posicao_atual = r_posicao_atual;

endmodule

// File: tb/tb_controle_servo_pwm.sv
// -----------------------------------------------------------------------------
// tb_controle_servo_pwm
//
// Self-checking bench for controle_servo_pwm with PERIODO=20, LARG_MIN=4,
// PASSO=2, N=3, W=5. A cycle-stamped model predicts every output each cycle;
// directed phases add hand-computed pulse counts and position values.
// -----------------------------------------------------------------------------
module tb_controle_servo_pwm;

  localparam int PERIODO  = 20;
  localparam int LARG_MIN = 4;
  localparam int PASSO    = 2;
  localparam int N        = 3;
  localparam int W        = 5;

  logic         clock;
  logic         zera_as_n;
  logic         liga;
  logic [N-1:0] posicao_dir;
  logic [N-1:0] posicao;
  logic         pwm;
  logic         fim_periodo;
  logic         ativo;
  logic [N-1:0] posicao_atual;

  int checks = 0;
  int errors = 0;

  controle_servo_pwm #(
    .PERIODO (PERIODO),
    .LARG_MIN(LARG_MIN),
    .PASSO   (PASSO),
    .N       (N),
    .W       (W)
  ) dut (
    .clock        (clock),
    .zera_as_n    (zera_as_n),
    .liga         (liga),
    .posicao      (posicao),
    .pwm          (pwm),
    .fim_periodo  (fim_periodo),
    .ativo        (ativo),
    .posicao_atual(posicao_atual)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in for the up/down position counter in loop-back mode: counts up
  // (mod 8) whenever fim_periodo is high at an edge.
  logic         loop_mode;
  logic [N-1:0] q_contador;
  always @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n)       q_contador <= '0;
    else if (fim_periodo) q_contador <= q_contador + 3'd1;
  end
  assign posicao = loop_mode ? q_contador : posicao_dir;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: a period is described by its start cycle and its position. Cycle
  // index = number of rising edges seen so far. Outputs follow from the phase
  // (cycle - start) with plain arithmetic.
  // ---------------------------------------------------------------------------
  int cyc   = 0;
  bit m_on  = 1'b0;
  int m_t0  = 0;
  int m_pos = 0;

  function automatic int larg(input int p);
    int v;
    v = LARG_MIN + p * PASSO;
    return (v > PERIODO - 1) ? PERIODO - 1 : v;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      m_on  <= 1'b0;
      m_pos <= 0;
    end else if (!m_on) begin
      if (liga) begin
        m_on  <= 1'b1;
        m_t0  <= cyc + 1;
        m_pos <= int'(posicao);
      end
    end else if (cyc - m_t0 == PERIODO - 1) begin
      m_on  <= liga;
      m_t0  <= cyc + 1;
      m_pos <= int'(posicao);
    end
  end

  // Per-cycle compare, sampled 1 time unit after each rising edge.
  always @(posedge clock) begin
    int fase;
    #1;
    fase = cyc - m_t0;
    check("pwm",           32'(pwm),           32'(m_on && (fase < larg(m_pos))));
    check("fim_periodo",   32'(fim_periodo),   32'(m_on && (fase == PERIODO - 1)));
    check("ativo",         32'(ativo),         32'(m_on));
    check("posicao_atual", 32'(posicao_atual), 32'(m_pos));
  end

  // Runs n cycles (sampling after each edge) and tallies what was seen.
  task automatic run_cycles(input int n, output int hi, output int fims,
                            output int ativos, output logic first_pwm,
                            output int last_pos);
    hi = 0; fims = 0; ativos = 0; first_pwm = 1'b0; last_pos = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (i == 0) first_pwm = pwm;
      hi       += int'(pwm);
      fims     += int'(fim_periodo);
      ativos   += int'(ativo);
      last_pos  = int'(posicao_atual);
    end
  endtask

  initial begin
    int   hi, fims, ats, lp, hi2, fims2, ats2;
    logic fp;
    int   exp_pos [9] = '{0, 0, 1, 2, 3, 4, 5, 6, 7};

    zera_as_n   = 1'b0;
    liga        = 1'b0;
    posicao_dir = '0;
    loop_mode   = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_pwm",   32'(pwm),           32'd0);
    check("reset_ativo", 32'(ativo),         32'd0);
    check("reset_pos",   32'(posicao_atual), 32'd0);
    @(negedge clock);
    zera_as_n = 1'b1;
    repeat (2) @(negedge clock);

    // Minimum width, three consecutive periods
    posicao_dir = 3'd0;
    liga        = 1'b1;
    for (int p = 0; p < 3; p++) begin
      run_cycles(PERIODO, hi, fims, ats, fp, lp);
      check("min_hi",    32'(hi),   32'd4);
      check("min_fim",   32'(fims), 32'd1);
      check("min_ativo", 32'(ats),  32'd20);
      check("min_first", 32'(fp),   32'd1);
    end

    // Maximum width
    @(negedge clock);
    posicao_dir = 3'd7;
    run_cycles(PERIODO, hi, fims, ats, fp, lp);
    check("max_hi",  32'(hi), 32'd18);
    check("max_pos", 32'(lp), 32'd7);

    // Mid-period change: 2 at the boundary, 5 after three cycles
    @(negedge clock);
    posicao_dir = 3'd2;
    run_cycles(3, hi, fims, ats, fp, lp);
    @(negedge clock);
    posicao_dir = 3'd5;
    run_cycles(PERIODO - 3, hi2, fims2, ats2, fp, lp);
    check("mid_hi_cur",  32'(hi + hi2), 32'd8);
    check("mid_pos_cur", 32'(lp),       32'd2);
    run_cycles(PERIODO, hi, fims, ats, fp, lp);
    check("mid_hi_next",  32'(hi), 32'd14);
    check("mid_pos_next", 32'(lp), 32'd5);

    // Stop at cycle 5: period completes, then stays idle
    run_cycles(5, hi, fims, ats, fp, lp);
    @(negedge clock);
    liga = 1'b0;
    run_cycles(PERIODO - 5, hi2, fims2, ats2, fp, lp);
    check("stop_hi",    32'(hi + hi2),     32'd14);
    check("stop_fim",   32'(fims + fims2), 32'd1);
    check("stop_ativo", 32'(ats + ats2),   32'd20);
    run_cycles(30, hi, fims, ats, fp, lp);
    check("idle_hi",    32'(hi),   32'd0);
    check("idle_fim",   32'(fims), 32'd0);
    check("idle_ativo", 32'(ats),  32'd0);

    // Restart from PARADO with position 1 (width 6)
    @(negedge clock);
    posicao_dir = 3'd1;
    liga        = 1'b1;
    run_cycles(PERIODO, hi, fims, ats, fp, lp);
    check("restart_first", 32'(fp),   32'd1);
    check("restart_hi",    32'(hi),   32'd6);
    check("restart_fim",   32'(fims), 32'd1);

    // Asynchronous reset mid-period with liga still high
    run_cycles(7, hi, fims, ats, fp, lp);
    @(posedge clock);
    #2;
    zera_as_n = 1'b0;
    loop_mode = 1'b1;
    #1;
    check("arst_pwm",   32'(pwm),           32'd0);
    check("arst_fim",   32'(fim_periodo),   32'd0);
    check("arst_ativo", 32'(ativo),         32'd0);
    check("arst_pos",   32'(posicao_atual), 32'd0);
    run_cycles(3, hi, fims, ats, fp, lp);
    check("arst_hold_hi",    32'(hi),  32'd0);
    check("arst_hold_ativo", 32'(ats), 32'd0);
    @(negedge clock);
    zera_as_n = 1'b1;

    // Loop-back with the position counter: one-period lag behind the counter
    for (int p = 0; p < 9; p++) begin
      run_cycles(PERIODO, hi, fims, ats, fp, lp);
      check("loop_pos", 32'(lp), 32'(exp_pos[p]));
      check("loop_hi",  32'(hi), 32'(4 + 2 * exp_pos[p]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
